// File: rtl/fir_pkg.sv
// Shared types and register-map helpers for the FIR tap sequencer.
// The datapath register file holds the accumulator, the delay line,
// the coefficient bank and one product temporary.
package fir_pkg;

  // Datapath opcodes, one issued per cycle.
  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_COPY  = 3'd1,
    OP_LOAD1 = 3'd2,
    OP_LOAD2 = 3'd3,
    OP_ADD   = 3'd4,
    OP_SUB   = 3'd5,
    OP_MUL   = 3'd6
  } op_t;

  // Sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COEFF   = 3'd1,
    ST_SHIFT   = 3'd2,
    ST_LOAD    = 3'd3,
    ST_MAC_MUL = 3'd4,
    ST_MAC_ADD = 3'd5,
    ST_DONE    = 3'd6,
    ST_ERR     = 3'd7
  } state_t;

  // Width of the shared step counter (tap count never exceeds 7).
  localparam int STEP_W = 3;

  // Accumulator / output register.
  localparam logic [3:0] ACC_REG = 4'd0;

  // Delay-line register holding tap k (k = 0 is the newest sample, in R1).
  function automatic logic [3:0] sample_reg(input logic [3:0] k);
    return k + 4'd1;
  endfunction

  // Coefficient register for tap k in an n-tap filter.
  function automatic logic [3:0] coeff_reg(input logic [3:0] n, input logic [3:0] k);
    return n + k + 4'd1;
  endfunction

  // Product temporary, located just past the coefficient bank.
  function automatic logic [3:0] temp_reg(input logic [3:0] n);
    return (n << 1) + 4'd1;
  endfunction

endpackage

// File: rtl/fir_step_counter.sv
// Loadable down-counter shared by the coefficient, shift and MAC phases.
// tc_o flags the last step of a phase (count has reached zero).
module fir_step_counter
  import fir_pkg::*;
#(
  parameter int W = STEP_W
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         load_i,
  input  logic         dec_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;

  // Count register: load has priority over decrement, and it never wraps below zero.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == '0);

endmodule

// File: rtl/fir_tap_sequencer.sv
// Sequencer for the shared FIR datapath: coefficient bursts and per-sample
// convolution (shift delay line, load new sample, multiply-accumulate).
// The opcode and register indices are decoded from the current state and
// the step counter; the clear/overrun pulses are registered flags.
module fir_tap_sequencer
  import fir_pkg::*;
#(
  parameter int NUM_TAPS = 4
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       data_ready,
  input  logic       load_coeff,
  input  logic       coeff_valid,
  output logic       coeff_ready,
  input  logic       overflow,
  output logic [2:0] op,
  output logic [3:0] src1,
  output logic [3:0] src2,
  output logic [3:0] dest,
  output logic       modwait,
  output logic       cnt_up,
  output logic       clear,
  output logic       err,
  output logic       overrun
);

  localparam logic [STEP_W-1:0] LAST_K     = STEP_W'(NUM_TAPS - 1);
  localparam logic [STEP_W-1:0] SHIFT_INIT = STEP_W'(NUM_TAPS - 2);
  localparam logic [3:0]        TAPS       = 4'(NUM_TAPS);

  state_t              state_q, state_d;
  logic                pend_sample_q, pend_sample_d;
  logic                pend_coeff_q, pend_coeff_d;
  logic                clear_q, clear_d;
  logic                overrun_q, overrun_d;

  logic                ctr_load_s;
  logic                ctr_dec_s;
  logic [STEP_W-1:0]   ctr_val_s;
  logic [STEP_W-1:0]   cnt_s;
  logic                tc_s;
  logic [STEP_W-1:0]   k_s;
  logic                busy_s;

  op_t                 op_s;
  logic [3:0]          src1_s, src2_s, dest_s;

  fir_step_counter #(
    .W (STEP_W)
  ) u_step (
    .clk        (clk),
    .n_rst      (n_rst),
    .load_i     (ctr_load_s),
    .dec_i      (ctr_dec_s),
    .load_val_i (ctr_val_s),
    .cnt_o      (cnt_s),
    .tc_o       (tc_s)
  );

  // Tap / coefficient index counts up while the step counter counts down.
  assign k_s    = LAST_K - cnt_s;
  assign busy_s = (state_q != ST_IDLE) && (state_q != ST_ERR);

  // Next-state, pending-request bookkeeping and step-counter control.
  always_comb begin
    state_d       = state_q;
    pend_sample_d = pend_sample_q;
    pend_coeff_d  = pend_coeff_q;
    clear_d       = 1'b0;
    overrun_d     = 1'b0;
    ctr_load_s    = 1'b0;
    ctr_dec_s     = 1'b0;
    ctr_val_s     = '0;

    // Requests arriving while a sequence runs are parked in 1-deep slots.
    if (busy_s) begin
      if (data_ready) begin
        if (pend_sample_q) begin
          overrun_d = 1'b1;
        end else begin
          pend_sample_d = 1'b1;
        end
      end else begin
        pend_sample_d = pend_sample_q;
      end
      if (load_coeff && (state_q != ST_COEFF)) begin
        pend_coeff_d = 1'b1;
      end else begin
        pend_coeff_d = pend_coeff_q;
      end
    end else begin
      pend_coeff_d = pend_coeff_q;
    end

    case (state_q)
      ST_IDLE, ST_ERR: begin
        // A coefficient burst outranks a sample; a coincident sample is parked.
        if (load_coeff || pend_coeff_q) begin
          state_d      = ST_COEFF;
          ctr_load_s   = 1'b1;
          ctr_val_s    = LAST_K;
          pend_coeff_d = 1'b0;
          if (data_ready) begin
            if (pend_sample_q) begin
              overrun_d = 1'b1;
            end else begin
              pend_sample_d = 1'b1;
            end
          end else begin
            pend_sample_d = pend_sample_q;
          end
        end else if (data_ready || pend_sample_q) begin
          // Serve the parked sample first; a fresh one then takes the slot.
          state_d       = ST_SHIFT;
          ctr_load_s    = 1'b1;
          ctr_val_s     = SHIFT_INIT;
          pend_sample_d = pend_sample_q & data_ready;
        end else begin
          state_d = state_q;
        end
      end
      ST_COEFF: begin
        if (coeff_valid) begin
          if (tc_s) begin
            state_d = ST_IDLE;
            clear_d = 1'b1;
          end else begin
            ctr_dec_s = 1'b1;
          end
        end else begin
          ctr_dec_s = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (tc_s) begin
          state_d = ST_LOAD;
        end else begin
          ctr_dec_s = 1'b1;
        end
      end
      ST_LOAD: begin
        state_d    = ST_MAC_MUL;
        ctr_load_s = 1'b1;
        ctr_val_s  = LAST_K;
      end
      ST_MAC_MUL: begin
        if (overflow) begin
          state_d = ST_ERR;
        end else if (cnt_s == LAST_K) begin
          // Tap 0 product lands straight in the accumulator; no add follows.
          ctr_dec_s = 1'b1;
        end else begin
          state_d = ST_MAC_ADD;
        end
      end
      ST_MAC_ADD: begin
        if (overflow) begin
          state_d = ST_ERR;
        end else if (tc_s) begin
          state_d = ST_DONE;
        end else begin
          ctr_dec_s = 1'b1;
          state_d   = ST_MAC_MUL;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and flag registers with synchronous reset; datapath contents are not ours to clear.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      state_q       <= ST_IDLE;
      pend_sample_q <= 1'b0;
      pend_coeff_q  <= 1'b0;
      clear_q       <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      pend_sample_q <= pend_sample_d;
      pend_coeff_q  <= pend_coeff_d;
      clear_q       <= clear_d;
      overrun_q     <= overrun_d;
    end
  end

  // Datapath command decode from state and the current step index.
  always_comb begin
    op_s   = OP_NOP;
    src1_s = 4'd0;
    src2_s = 4'd0;
    dest_s = 4'd0;
    case (state_q)
      ST_COEFF: begin
        if (coeff_valid) begin
          op_s   = OP_LOAD2;
          dest_s = coeff_reg(TAPS, {1'b0, k_s});
        end else begin
          op_s = OP_NOP;
        end
      end
      ST_SHIFT: begin
        // Oldest first: R(cnt+2) <= R(cnt+1), cnt counting down to zero.
        op_s   = OP_COPY;
        src1_s = sample_reg({1'b0, cnt_s});
        dest_s = sample_reg({1'b0, cnt_s} + 4'd1);
      end
      ST_LOAD: begin
        op_s   = OP_LOAD1;
        dest_s = sample_reg(4'd0);
      end
      ST_MAC_MUL: begin
        op_s   = OP_MUL;
        src1_s = sample_reg({1'b0, k_s});
        src2_s = coeff_reg(TAPS, {1'b0, k_s});
        if (k_s == '0) begin
          dest_s = ACC_REG;
        end else begin
          dest_s = temp_reg(TAPS);
        end
      end
      ST_MAC_ADD: begin
        op_s   = OP_ADD;
        src1_s = ACC_REG;
        src2_s = temp_reg(TAPS);
        dest_s = ACC_REG;
      end
      default: begin
        op_s = OP_NOP;
      end
    endcase
  end

  assign op          = op_s;
  assign src1        = src1_s;
  assign src2        = src2_s;
  assign dest        = dest_s;
  assign coeff_ready = (state_q == ST_COEFF);
  assign modwait     = busy_s;
  assign cnt_up      = (state_q == ST_DONE);
  assign err         = (state_q == ST_ERR);
  assign clear       = clear_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Self-checking bench for fir_tap_sequencer: a transaction-level model
// (per-sample op list, pending slots, coefficient/sample history) predicts
// every output each cycle, and a datapath model executes the issued ops so
// the accumulator can be checked against a direct convolution sum.
module tb_fir_tap_sequencer;

  localparam int N    = 4;
  localparam int QLEN = 3 * N;
  localparam int TMP  = 2 * N + 1;

  localparam int OPC_NOP = 0, OPC_COPY = 1, OPC_LOAD1 = 2, OPC_LOAD2 = 3;
  localparam int OPC_ADD = 4, OPC_MUL = 6;
  localparam int M_IDLE = 0, M_COEFF = 1, M_SAMPLE = 2, M_ERR = 3;

  logic       clk = 1'b0;
  logic       n_rst, data_ready, load_coeff, coeff_valid, overflow;
  logic       coeff_ready, modwait, cnt_up, clear, err, overrun;
  logic [2:0] op;
  logic [3:0] src1, src2, dest;

  fir_tap_sequencer #(.NUM_TAPS(N)) dut (
    .clk(clk), .n_rst(n_rst), .data_ready(data_ready), .load_coeff(load_coeff),
    .coeff_valid(coeff_valid), .coeff_ready(coeff_ready), .overflow(overflow),
    .op(op), .src1(src1), .src2(src2), .dest(dest), .modwait(modwait),
    .cnt_up(cnt_up), .clear(clear), .err(err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // model state
  int          mode, ck, pos, ovf_pos;
  bit          pend_s, pend_c, e_clear, e_overrun, rand_ovf;
  int          qop[QLEN], qs1[QLEN], qs2[QLEN], qd[QLEN];
  logic [31:0] coef[N], hist[N], dp[16];
  logic [31:0] sq[$];
  logic [31:0] ext1, ext2;

  // observation
  logic [31:0] obs_err, obs_modwait;
  int          cnt_up_seen, clear_seen, overrun_seen, modwait_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] conv();
    logic [31:0] s = 32'd0;
    for (int k = 0; k < N; k++) s = s + hist[k] * coef[k];
    return s;
  endfunction

  // The op list one sample must produce, straight from the register map.
  task automatic build_seq();
    int n = 0;
    for (int i = N; i >= 2; i--) begin
      qop[n] = OPC_COPY; qs1[n] = i - 1; qs2[n] = 0; qd[n] = i; n++;
    end
    qop[n] = OPC_LOAD1; qs1[n] = 0; qs2[n] = 0; qd[n] = 1; n++;
    qop[n] = OPC_MUL; qs1[n] = 1; qs2[n] = N + 1; qd[n] = 0; n++;
    for (int k = 1; k < N; k++) begin
      qop[n] = OPC_MUL; qs1[n] = k + 1; qs2[n] = N + 1 + k; qd[n] = TMP; n++;
      qop[n] = OPC_ADD; qs1[n] = 0; qs2[n] = TMP; qd[n] = 0; n++;
    end
    qop[n] = OPC_NOP; qs1[n] = 0; qs2[n] = 0; qd[n] = 0;
    pos = 0;
    if (rand_ovf) begin
      if ($urandom_range(0, 5) == 0) ovf_pos = N + int'($urandom_range(0, 2 * N - 2));
      else ovf_pos = -1;
    end
  endtask

  task automatic park_sample(input logic [31:0] sv, inout bit novr);
    if (pend_s) novr = 1'b1;
    else begin pend_s = 1'b1; sq.push_back(sv); end
  endtask

  task automatic model_step(input logic dr, input logic [31:0] sv, input logic lc,
                            input logic cv, input logic [31:0] cval, input logic rst);
    bit novr = 1'b0;
    bit nclr = 1'b0;
    if (rst) begin
      mode = M_IDLE; pend_s = 1'b0; pend_c = 1'b0; ovf_pos = -1;
      e_clear = 1'b0; e_overrun = 1'b0; sq.delete();
      return;
    end
    case (mode)
      M_IDLE, M_ERR: begin
        if (lc || pend_c) begin
          mode = M_COEFF; ck = 0; pend_c = 1'b0;
          if (dr) park_sample(sv, novr);
        end else if (dr || pend_s) begin
          if (dr) sq.push_back(sv);
          pend_s = pend_s && dr;
          build_seq();
          mode = M_SAMPLE;
        end
      end
      M_COEFF: begin
        if (dr) park_sample(sv, novr);
        if (cv) begin
          coef[ck] = cval; ck++;
          if (ck == N) begin mode = M_IDLE; nclr = 1'b1; end
        end
      end
      default: begin
        if (dr) park_sample(sv, novr);
        if (lc) pend_c = 1'b1;
        if (overflow && (qop[pos] == OPC_MUL || qop[pos] == OPC_ADD)) begin
          mode = M_ERR; ovf_pos = -1;
        end else if (pos == QLEN - 1) begin
          mode = M_IDLE;
        end else begin
          if (qop[pos] == OPC_LOAD1) begin
            for (int i = N - 1; i > 0; i--) hist[i] = hist[i - 1];
            hist[0] = (sq.size() > 0) ? sq.pop_front() : 32'd0;
          end
          pos++;
        end
      end
    endcase
    e_clear = nclr; e_overrun = novr;
  endtask

  // One clock cycle: drive, predict, compare, run datapath, advance model.
  task automatic tick(input logic dr, input logic [31:0] sv, input logic lc,
                      input logic cv, input logic [31:0] cval, input logic rst);
    logic [31:0] e_op, e_s1, e_s2, e_d, e_mw, e_cu, e_err, e_cr;
    @(negedge clk);
    n_rst = rst; data_ready = dr; load_coeff = lc; coeff_valid = cv; ext2 = cval;
    ext1 = (sq.size() > 0) ? sq[0] : 32'd0;
    e_op = 0; e_s1 = 0; e_s2 = 0; e_d = 0; e_mw = 0; e_cu = 0; e_err = 0; e_cr = 0;
    case (mode)
      M_COEFF: begin
        e_mw = 1; e_cr = 1;
        if (cv) begin e_op = OPC_LOAD2; e_d = 32'(N + 1 + ck); end
      end
      M_SAMPLE: begin
        e_mw = 1; e_op = qop[pos]; e_s1 = qs1[pos]; e_s2 = qs2[pos]; e_d = qd[pos];
        e_cu = (pos == QLEN - 1) ? 32'd1 : 32'd0;
      end
      M_ERR: e_err = 1;
      default: ;
    endcase
    overflow = (mode == M_SAMPLE) && (pos == ovf_pos);
    #1;
    obs_err = 32'(err); obs_modwait = 32'(modwait);
    chk("op", 32'(op), e_op);
    chk("src1", 32'(src1), e_s1);
    chk("src2", 32'(src2), e_s2);
    chk("dest", 32'(dest), e_d);
    chk("modwait", 32'(modwait), e_mw);
    chk("cnt_up", 32'(cnt_up), e_cu);
    chk("err", 32'(err), e_err);
    chk("coeff_ready", 32'(coeff_ready), e_cr);
    chk("clear", 32'(clear), 32'(e_clear));
    chk("overrun", 32'(overrun), 32'(e_overrun));
    if (mode == M_SAMPLE && pos == QLEN - 1) chk("r0_result", dp[0], conv());
    cnt_up_seen += int'(cnt_up); clear_seen += int'(clear);
    overrun_seen += int'(overrun); modwait_seen += int'(modwait);
    case (int'(op))
      OPC_COPY:  dp[dest] = dp[src1];
      OPC_LOAD1: dp[dest] = ext1;
      OPC_LOAD2: dp[dest] = ext2;
      OPC_ADD:   dp[dest] = dp[src1] + dp[src2];
      5:         dp[dest] = dp[src1] - dp[src2];
      OPC_MUL:   dp[dest] = dp[src1] * dp[src2];
      default: ;
    endcase
    model_step(dr, sv, lc, cv, cval, rst);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic run_idle(input int budget);
    int i = 0;
    while (i < budget && !(mode == M_IDLE && !pend_s && !pend_c)) begin
      tick(1'b0, 32'd0, 1'b0, 1'b1, 32'd0, 1'b0);
      i++;
    end
    tick(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    chk("drain_modwait", obs_modwait, 32'd0);
  endtask

  task automatic clr_seen();
    cnt_up_seen = 0; clear_seen = 0; overrun_seen = 0; modwait_seen = 0;
  endtask

  initial begin
    n_rst = 1'b1; data_ready = 1'b0; load_coeff = 1'b0; coeff_valid = 1'b0; overflow = 1'b0;
    mode = M_IDLE; ck = 0; pos = 0; ovf_pos = -1; pend_s = 0; pend_c = 0;
    e_clear = 0; e_overrun = 0; rand_ovf = 0;
    for (int i = 0; i < 16; i++) dp[i] = 32'd0;
    for (int i = 0; i < N; i++) begin coef[i] = 32'd0; hist[i] = 32'd0; end
    clr_seen();
    repeat (3) @(posedge clk);

    // reset, then 10 quiet cycles
    tick(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);
    clr_seen();
    idle(10);
    chk("idle_modwait_cycles", 32'(modwait_seen), 32'd0);
    chk("idle_pulses", 32'(cnt_up_seen + clear_seen + overrun_seen), 32'd0);

    // coefficient burst 1,2,3,4
    clr_seen();
    tick(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0);
    for (int i = 1; i <= 4; i++) tick(1'b0, 32'd0, 1'b0, 1'b1, 32'(i), 1'b0);
    idle(2);
    chk("burst_clear_count", 32'(clear_seen), 32'd1);
    chk("coef_r5", dp[5], 32'd1);
    chk("coef_r8", dp[8], 32'd4);

    // samples 10 then 20 -> R0 = 20*1 + 10*2 = 40
    tick(1'b1, 32'd10, 1'b0, 1'b0, 32'd0, 1'b0);
    run_idle(40);
    clr_seen();
    tick(1'b1, 32'd20, 1'b0, 1'b0, 32'd0, 1'b0);
    run_idle(40);
    chk("r0_literal_40", dp[0], 32'd40);
    chk("modwait_cycles", 32'(modwait_seen), 32'd12);
    chk("cnt_up_count", 32'(cnt_up_seen), 32'd1);

    // overflow on the third MAC op aborts; next sample clears err
    clr_seen();
    ovf_pos = N + 2;
    tick(1'b1, 32'd30, 1'b0, 1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 20 && mode != M_ERR; i++) tick(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    idle(2);
    chk("err_set", obs_err, 32'd1);
    chk("abort_no_cnt_up", 32'(cnt_up_seen), 32'd0);
    tick(1'b1, 32'd5, 1'b0, 1'b0, 32'd0, 1'b0);
    tick(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    chk("err_cleared", obs_err, 32'd0);
    run_idle(40);

    // two arrivals while busy: first parked, second dropped
    clr_seen();
    tick(1'b1, 32'd7, 1'b0, 1'b0, 32'd0, 1'b0);
    idle(2);
    tick(1'b1, 32'd8, 1'b0, 1'b0, 32'd0, 1'b0);
    idle(1);
    tick(1'b1, 32'd9, 1'b0, 1'b0, 32'd0, 1'b0);
    run_idle(60);
    chk("overrun_count", 32'(overrun_seen), 32'd1);
    chk("busy_cnt_up_count", 32'(cnt_up_seen), 32'd2);

    // load_coeff and data_ready together: burst first, then sample
    clr_seen();
    tick(1'b1, 32'd3, 1'b1, 1'b0, 32'd0, 1'b0);
    for (int i = 2; i <= 5; i++) tick(1'b0, 32'd0, 1'b0, 1'b1, 32'(i), 1'b0);
    run_idle(40);
    chk("combo_clear_count", 32'(clear_seen), 32'd1);
    chk("combo_cnt_up_count", 32'(cnt_up_seen), 32'd1);

    // reset during MAC with a sample parked
    tick(1'b1, 32'd11, 1'b0, 1'b0, 32'd0, 1'b0);
    tick(1'b1, 32'd12, 1'b0, 1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 20 && !(mode == M_SAMPLE && pos >= N + 1); i++)
      tick(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    tick(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);
    clr_seen();
    idle(10);
    chk("rst_no_cnt_up", 32'(cnt_up_seen), 32'd0);
    chk("rst_no_modwait", 32'(modwait_seen), 32'd0);

    // randomized traffic
    rand_ovf = 1'b1;
    for (int i = 0; i < 600; i++)
      tick($urandom_range(0, 5) == 0, 32'($urandom_range(0, 255)),
           $urandom_range(0, 39) == 0, 1'($urandom_range(0, 1)),
           32'($urandom_range(0, 15)), 1'b0);
    rand_ovf = 1'b0;
    ovf_pos = -1;
    run_idle(80);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
